// File: rtl/mem_instr_sequencer_if.sv
// Control bus between the memory-instruction sequencer and the datapath.
// master = sequencer side, slave = datapath / stimulus side.
interface mem_instr_sequencer_if;
   logic       start;
   logic [4:0] ir_op;
   logic       PCout, MARin, IncPC, RZin, RZLOout, PCin;
   logic       Read, Write, MDRin, MDRout, IRin;
   logic       gra, grb, rin, rout, BAout, RYin, Cout;
   logic [4:0] ops;
   logic       busy, done, illegal;
   logic [3:0] state;

   modport master (
      input  start, ir_op,
      output PCout, MARin, IncPC, RZin, RZLOout, PCin,
             Read, Write, MDRin, MDRout, IRin,
             gra, grb, rin, rout, BAout, RYin, Cout,
             ops, busy, done, illegal, state
   );

   modport slave (
      output start, ir_op,
      input  PCout, MARin, IncPC, RZin, RZLOout, PCin,
             Read, Write, MDRin, MDRout, IRin,
             gra, grb, rin, rout, BAout, RYin, Cout,
             ops, busy, done, illegal, state
   );
endinterface

// File: rtl/mem_instr_sequencer.sv
// Hardwired fetch + ld/ldi/st control sequencer. Moore FSM: every strobe is a
// register loaded with the value belonging to the state being entered, so the
// outputs are clean for the whole cycle of each state.
module mem_instr_sequencer #(
   parameter int         MEM_WAIT = 0,
   parameter logic [4:0] ADD_OP   = 5'b00011,
   parameter logic [4:0] OP_LD    = 5'b00000,
   parameter logic [4:0] OP_LDI   = 5'b00001,
   parameter logic [4:0] OP_ST    = 5'b00010
) (
   input  logic                  clock,
   input  logic                  clear,
   mem_instr_sequencer_if.master bus
);

   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
      S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_DONE = 4'd9
   } state_t;

   typedef struct packed {
      logic PCout, MARin, IncPC, RZin, RZLOout, PCin;
      logic Read, Write, MDRin, MDRout, IRin;
      logic gra, grb, rin, rout, BAout, RYin, Cout;
   } strb_t;

   state_t     st;
   strb_t      strb;
   logic [2:0] wcnt;
   logic [4:0] op_q;
   logic [4:0] ops_q;
   logic       busy_q, done_q, illegal_q;

   logic op_legal;
   assign op_legal = (bus.ir_op == OP_LD) || (bus.ir_op == OP_LDI) || (bus.ir_op == OP_ST);

   // State walk; each arm loads the strobes of the state it moves into.
   always_ff @(posedge clock) begin
      if (clear) begin
         st        <= S_IDLE;
         strb      <= '0;
         wcnt      <= '0;
         op_q      <= '0;
         ops_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         strb      <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (st)
            S_IDLE: begin
               if (bus.start) begin
                  st         <= S_T0;
                  busy_q     <= 1'b1;
                  strb.PCout <= 1'b1;
                  strb.MARin <= 1'b1;
                  strb.IncPC <= 1'b1;
                  strb.RZin  <= 1'b1;
               end
            end
            S_T0: begin
               // PC update rides only on the first memory cycle of the fetch.
               st           <= S_T1;
               wcnt         <= WAIT_INIT;
               strb.Read    <= 1'b1;
               strb.MDRin   <= 1'b1;
               strb.RZLOout <= 1'b1;
               strb.PCin    <= 1'b1;
            end
            S_T1: begin
               if (wcnt != 3'd0) begin
                  wcnt       <= wcnt - 3'd1;
                  strb.Read  <= 1'b1;
                  strb.MDRin <= 1'b1;
               end else begin
                  st          <= S_T2;
                  strb.MDRout <= 1'b1;
                  strb.IRin   <= 1'b1;
               end
            end
            S_T2: begin
               // Opcode is taken at the IR load edge; anything else aborts.
               if (op_legal) begin
                  st         <= S_T3;
                  op_q       <= bus.ir_op;
                  strb.grb   <= 1'b1;
                  strb.BAout <= 1'b1;
                  strb.RYin  <= 1'b1;
               end else begin
                  st        <= S_DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  illegal_q <= 1'b1;
               end
            end
            S_T3: begin
               st        <= S_T4;
               ops_q     <= ADD_OP;
               strb.Cout <= 1'b1;
               strb.RZin <= 1'b1;
            end
            S_T4: begin
               st           <= S_T5;
               strb.RZLOout <= 1'b1;
               if (op_q == OP_LDI) begin
                  strb.gra <= 1'b1;
                  strb.rin <= 1'b1;
               end else begin
                  strb.MARin <= 1'b1;
               end
            end
            S_T5: begin
               if (op_q == OP_LDI) begin
                  st     <= S_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else if (op_q == OP_LD) begin
                  st         <= S_T6;
                  wcnt       <= WAIT_INIT;
                  strb.Read  <= 1'b1;
                  strb.MDRin <= 1'b1;
               end else begin
                  st         <= S_T6;
                  strb.gra   <= 1'b1;
                  strb.rout  <= 1'b1;
                  strb.MDRin <= 1'b1;
               end
            end
            S_T6: begin
               if (op_q == OP_LD && wcnt != 3'd0) begin
                  wcnt       <= wcnt - 3'd1;
                  strb.Read  <= 1'b1;
                  strb.MDRin <= 1'b1;
               end else if (op_q == OP_LD) begin
                  st          <= S_T7;
                  strb.MDRout <= 1'b1;
                  strb.gra    <= 1'b1;
                  strb.rin    <= 1'b1;
               end else begin
                  st          <= S_T7;
                  wcnt        <= WAIT_INIT;
                  strb.MDRout <= 1'b1;
                  strb.Write  <= 1'b1;
               end
            end
            S_T7: begin
               if (op_q == OP_ST && wcnt != 3'd0) begin
                  wcnt        <= wcnt - 3'd1;
                  strb.MDRout <= 1'b1;
                  strb.Write  <= 1'b1;
               end else begin
                  st     <= S_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            S_DONE: begin
               st <= S_IDLE;
            end
            default: begin
               st     <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PCout   = strb.PCout;
   assign bus.MARin   = strb.MARin;
   assign bus.IncPC   = strb.IncPC;
   assign bus.RZin    = strb.RZin;
   assign bus.RZLOout = strb.RZLOout;
   assign bus.PCin    = strb.PCin;
   assign bus.Read    = strb.Read;
   assign bus.Write   = strb.Write;
   assign bus.MDRin   = strb.MDRin;
   assign bus.MDRout  = strb.MDRout;
   assign bus.IRin    = strb.IRin;
   assign bus.gra     = strb.gra;
   assign bus.grb     = strb.grb;
   assign bus.rin     = strb.rin;
   assign bus.rout    = strb.rout;
   assign bus.BAout   = strb.BAout;
   assign bus.RYin    = strb.RYin;
   assign bus.Cout    = strb.Cout;
   assign bus.ops     = ops_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.illegal = illegal_q;
   assign bus.state   = st;

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// Bench for mem_instr_sequencer: three instances with MEM_WAIT = 0/1/2.
// Expected per-cycle output words are queued at stimulus time; a negedge
// monitor pops one per busy/done cycle of the selected instance.
module tb_mem_instr_sequencer;

   localparam logic [4:0] ADD = 5'b00011;
   localparam logic [4:0] LD  = 5'b00000;
   localparam logic [4:0] LDI = 5'b00001;
   localparam logic [4:0] ST  = 5'b00010;

   typedef struct packed {
      logic pc_out, mar_in, inc_pc, rz_in, rzlo_out, pc_in;
      logic rd, wr, mdr_in, mdr_out, ir_in;
      logic gra, grb, rin, rout, ba_out, ry_in, c_out;
      logic [4:0] ops;
      logic busy, done, illegal;
      logic [3:0] state;
   } obs_t;

   localparam logic [17:0] PCOUT   = 18'(1) << 17;
   localparam logic [17:0] MARIN   = 18'(1) << 16;
   localparam logic [17:0] INCPC   = 18'(1) << 15;
   localparam logic [17:0] RZIN    = 18'(1) << 14;
   localparam logic [17:0] RZLOOUT = 18'(1) << 13;
   localparam logic [17:0] PCIN    = 18'(1) << 12;
   localparam logic [17:0] READ    = 18'(1) << 11;
   localparam logic [17:0] WRITE   = 18'(1) << 10;
   localparam logic [17:0] MDRIN   = 18'(1) << 9;
   localparam logic [17:0] MDROUT  = 18'(1) << 8;
   localparam logic [17:0] IRIN    = 18'(1) << 7;
   localparam logic [17:0] GRA     = 18'(1) << 6;
   localparam logic [17:0] GRB     = 18'(1) << 5;
   localparam logic [17:0] RIN     = 18'(1) << 4;
   localparam logic [17:0] ROUT    = 18'(1) << 3;
   localparam logic [17:0] BAOUT   = 18'(1) << 2;
   localparam logic [17:0] RYIN    = 18'(1) << 1;
   localparam logic [17:0] COUT    = 18'(1) << 0;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic [2:0] start_v = 3'b000;
   logic [4:0] ir_op_v = 5'b0;

   always #5 clock = ~clock;

   mem_instr_sequencer_if bus0 ();
   mem_instr_sequencer_if bus1 ();
   mem_instr_sequencer_if bus2 ();

   assign bus0.start = start_v[0];
   assign bus1.start = start_v[1];
   assign bus2.start = start_v[2];
   assign bus0.ir_op = ir_op_v;
   assign bus1.ir_op = ir_op_v;
   assign bus2.ir_op = ir_op_v;

   mem_instr_sequencer #(.MEM_WAIT(0)) u_dut0 (.clock(clock), .clear(clear), .bus(bus0.master));
   mem_instr_sequencer #(.MEM_WAIT(1)) u_dut1 (.clock(clock), .clear(clear), .bus(bus1.master));
   mem_instr_sequencer #(.MEM_WAIT(2)) u_dut2 (.clock(clock), .clear(clear), .bus(bus2.master));

   obs_t obs0, obs1, obs2, act;
   assign obs0 = {bus0.PCout, bus0.MARin, bus0.IncPC, bus0.RZin, bus0.RZLOout, bus0.PCin,
                  bus0.Read, bus0.Write, bus0.MDRin, bus0.MDRout, bus0.IRin,
                  bus0.gra, bus0.grb, bus0.rin, bus0.rout, bus0.BAout, bus0.RYin, bus0.Cout,
                  bus0.ops, bus0.busy, bus0.done, bus0.illegal, bus0.state};
   assign obs1 = {bus1.PCout, bus1.MARin, bus1.IncPC, bus1.RZin, bus1.RZLOout, bus1.PCin,
                  bus1.Read, bus1.Write, bus1.MDRin, bus1.MDRout, bus1.IRin,
                  bus1.gra, bus1.grb, bus1.rin, bus1.rout, bus1.BAout, bus1.RYin, bus1.Cout,
                  bus1.ops, bus1.busy, bus1.done, bus1.illegal, bus1.state};
   assign obs2 = {bus2.PCout, bus2.MARin, bus2.IncPC, bus2.RZin, bus2.RZLOout, bus2.PCin,
                  bus2.Read, bus2.Write, bus2.MDRin, bus2.MDRout, bus2.IRin,
                  bus2.gra, bus2.grb, bus2.rin, bus2.rout, bus2.BAout, bus2.RYin, bus2.Cout,
                  bus2.ops, bus2.busy, bus2.done, bus2.illegal, bus2.state};

   int sel = 0;
   always_comb act = (sel == 0) ? obs0 : (sel == 1) ? obs1 : obs2;

   obs_t       exp_q[$];
   obs_t       mon_e;
   logic [4:0] ops_held [3];
   int         n_run = 0;
   int         n_fail = 0;
   int         seq_len = 0;
   int         last_len = 0;

   // Scoreboard monitor: one expected word per busy/done cycle, plus bus-rule checks.
   always @(negedge clock) begin
      if (act.busy || act.done) begin
         n_run++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output dut=%0d act=%h (queue empty)", sel, act);
         end else begin
            mon_e = exp_q.pop_front();
            if (act !== mon_e) begin
               n_fail++;
               $display("FAIL seq_word dut=%0d len=%0d act=%h exp=%h", sel, seq_len, act, mon_e);
            end
         end
         n_run++;
         if ((act.rd && act.wr) ||
             ($countones({act.pc_out, act.rzlo_out, act.mdr_out, act.ba_out, act.rout, act.c_out}) > 1)) begin
            n_fail++;
            $display("FAIL bus_rule dut=%0d act=%h (need no Read+Write, <=1 driver)", sel, act);
         end
         seq_len++;
         if (act.done) begin
            last_len = seq_len;
            seq_len  = 0;
         end
      end
   end

   function automatic obs_t mk(input logic [17:0] s, input logic [3:0] stv, input logic [4:0] o,
                               input logic b, input logic d, input logic il);
      obs_t v;
      v = {s, o, b, d, il, stv};
      return v;
   endfunction

   // Queue the spec's cycle-by-cycle sequence for one instruction; 'cut' limits words queued.
   task automatic gen_seq(input int w, input logic [4:0] op, input int cut);
      obs_t v[$];
      logic [4:0] oh;
      oh = ops_held[w];
      v.push_back(mk(PCOUT | MARIN | INCPC | RZIN, 4'd1, oh, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i <= w; i++)
         v.push_back(mk(READ | MDRIN | ((i == 0) ? (RZLOOUT | PCIN) : 18'd0), 4'd2, oh, 1'b1, 1'b0, 1'b0));
      v.push_back(mk(MDROUT | IRIN, 4'd3, oh, 1'b1, 1'b0, 1'b0));
      if (op != LD && op != LDI && op != ST) begin
         v.push_back(mk(18'd0, 4'd9, oh, 1'b0, 1'b1, 1'b1));
      end else begin
         v.push_back(mk(GRB | BAOUT | RYIN, 4'd4, oh, 1'b1, 1'b0, 1'b0));
         v.push_back(mk(COUT | RZIN, 4'd5, ADD, 1'b1, 1'b0, 1'b0));
         ops_held[w] = ADD;
         if (op == LDI) begin
            v.push_back(mk(RZLOOUT | GRA | RIN, 4'd6, ADD, 1'b1, 1'b0, 1'b0));
         end else begin
            v.push_back(mk(RZLOOUT | MARIN, 4'd6, ADD, 1'b1, 1'b0, 1'b0));
            if (op == LD) begin
               for (int i = 0; i <= w; i++)
                  v.push_back(mk(READ | MDRIN, 4'd7, ADD, 1'b1, 1'b0, 1'b0));
               v.push_back(mk(MDROUT | GRA | RIN, 4'd8, ADD, 1'b1, 1'b0, 1'b0));
            end else begin
               v.push_back(mk(GRA | ROUT | MDRIN, 4'd7, ADD, 1'b1, 1'b0, 1'b0));
               for (int i = 0; i <= w; i++)
                  v.push_back(mk(MDROUT | WRITE, 4'd8, ADD, 1'b1, 1'b0, 1'b0));
            end
         end
         v.push_back(mk(18'd0, 4'd9, ADD, 1'b0, 1'b1, 1'b0));
      end
      for (int i = 0; i < v.size() && i < cut; i++) exp_q.push_back(v[i]);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 60; i++) begin
         @(posedge clock);
         if (exp_q.size() == 0) break;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL %s_timeout left=%0d words (need 0)", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_obs(input string name, input obs_t a, input obs_t e);
      n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", name, a, e);
      end
   endtask

   task automatic check_len(input string name, input int exp_len);
      n_run++;
      if (last_len != exp_len) begin
         n_fail++;
         $display("FAIL %s_len act=%0d exp=%0d", name, last_len, exp_len);
      end
   endtask

   // One full sequence on instance s (MEM_WAIT = s); hold keeps start high while busy.
   task automatic run(input string name, input int s, input logic [4:0] op,
                      input int exp_len, input bit hold);
      sel      = s;
      ir_op_v  = op;
      last_len = 0;
      seq_len  = 0;
      gen_seq(s, op, 1000);
      @(negedge clock);
      start_v[s] = 1'b1;
      if (!hold) begin
         @(negedge clock);
         start_v[s] = 1'b0;
      end
      wait_drain(name);
      start_v[s] = 1'b0;
      check_len(name, exp_len);
      @(negedge clock);
      #1;
      check_obs({name, "_idle"}, act, mk(18'd0, 4'd0, ops_held[s], 1'b0, 1'b0, 1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog (simulation did not finish)");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) ops_held[i] = 5'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_obs("reset_dut0", obs0, '0);
      check_obs("reset_dut1", obs1, '0);
      check_obs("reset_dut2", obs2, '0);
      clear = 1'b0;

      run("ld_w0",       0, LD,       9,  1'b0);
      run("ld_w2_hold",  2, LD,       13, 1'b1);
      run("ldi_w0",      0, LDI,      7,  1'b0);
      run("st_w1",       1, ST,       11, 1'b0);
      run("illegal_w0",  0, 5'b11111, 4,  1'b0);
      run("illegal_w1",  1, 5'b00011, 5,  1'b0);
      run("st_w2",       2, ST,       13, 1'b0);
      run("ldi_w2",      2, LDI,      9,  1'b0);

      // clear during T5 of ld with start held high, then restart
      sel      = 0;
      ir_op_v  = LD;
      last_len = 0;
      seq_len  = 0;
      gen_seq(0, LD, 6);
      @(negedge clock);
      start_v[0] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         #1;
         if (exp_q.size() == 0) break;
      end
      if (exp_q.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL clr_reach_t5 left=%0d words (need 0)", exp_q.size());
         exp_q.delete();
      end
      clear = 1'b1;
      @(negedge clock);
      #1;
      check_obs("clr_zero", act, '0);
      check_len("clr_no_done", 0);
      for (int i = 0; i < 3; i++) ops_held[i] = 5'd0;
      seq_len = 0;
      gen_seq(0, LD, 1000);
      clear = 1'b0;
      wait_drain("clr_restart");
      start_v[0] = 1'b0;
      check_len("clr_restart", 9);
      @(negedge clock);
      #1;
      check_obs("clr_restart_idle", act, mk(18'd0, 4'd0, ADD, 1'b0, 1'b0, 1'b0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
